// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RISC-V control path: state codes,
// opcodes, ALUOp codes and datapath mux encodings.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Where DECODE dispatches an opcode; unsupported opcodes map to FETCH.
    function automatic state_t decode_target(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_R:         decode_target = S_EXECR;
            OP_I:         decode_target = S_EXECI;
            OP_BEQ:       decode_target = S_BEQ;
            OP_JAL:       decode_target = S_JAL;
            default:      decode_target = S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/main_fsm_instr_dec.sv
// Immediate-format select derived purely from the opcode.
module instr_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // Opcode to immediate format; R-type and unknown opcodes use I.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Moore control FSM for the multicycle RISC-V datapath.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instr at PC, PC+4; waits on mem_ready
// DECODE   | read regs, OldPC+imm target, dispatch on op
// MEMADR   | compute load/store address RD1+imm
// MEMREAD  | load data access; waits on mem_ready
// MEMWB    | write loaded data to register file
// MEMWRITE | store access; waits on mem_ready
// EXECR    | ALU op RD1 with RD2, funct-decoded
// EXECI    | ALU op RD1 with imm, funct-decoded
// ALUWB    | write ALU result register to register file
// BEQ      | compare RD1-RD2, load branch target on zero
// JAL      | PC <- target, ALU computes OldPC+4 for link
module main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state;
    state_t     state_next;

    logic       pc_update;
    logic       branch;
    logic       s_adr_src;
    logic       s_mem_write;
    logic       s_ir_write;
    logic       s_reg_write;
    logic [1:0] s_result_src;
    logic [1:0] s_alu_src_a;
    logic [1:0] s_alu_src_b;
    logic [1:0] s_alu_op;
    logic       s_done;
    logic       s_illegal;

    instr_dec u_instr_dec (
        .op      (op),
        .imm_src (imm_src)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_next   = S_FETCH;
        pc_update    = 1'b0;
        branch       = 1'b0;
        s_adr_src    = 1'b0;
        s_mem_write  = 1'b0;
        s_ir_write   = 1'b0;
        s_reg_write  = 1'b0;
        s_result_src = RES_ALUOUT;
        s_alu_src_a  = SRCA_PC;
        s_alu_src_b  = SRCB_RD2;
        s_alu_op     = ALUOP_ADD;
        s_done       = 1'b0;
        s_illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                s_ir_write   = mem_ready;
                pc_update    = mem_ready;
                s_alu_src_b  = SRCB_FOUR;
                s_result_src = RES_ALURESULT;
                state_next   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                s_alu_src_a = SRCA_OLDPC;
                s_alu_src_b = SRCB_IMM;
                state_next  = decode_target(op);
                s_illegal   = (decode_target(op) == S_FETCH);
            end
            S_MEMADR: begin
                s_alu_src_a = SRCA_RD1;
                s_alu_src_b = SRCB_IMM;
                state_next  = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                s_adr_src  = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                s_result_src = RES_DATA;
                s_reg_write  = 1'b1;
                s_done       = 1'b1;
            end
            S_MEMWRITE: begin
                s_adr_src   = 1'b1;
                s_mem_write = 1'b1;
                s_done      = mem_ready;
                state_next  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                s_alu_src_a = SRCA_RD1;
                s_alu_src_b = SRCB_RD2;
                s_alu_op    = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                s_alu_src_a = SRCA_RD1;
                s_alu_src_b = SRCB_IMM;
                s_alu_op    = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                s_reg_write = 1'b1;
                s_done      = 1'b1;
            end
            S_BEQ: begin
                s_alu_src_a = SRCA_RD1;
                s_alu_src_b = SRCB_RD2;
                s_alu_op    = ALUOP_SUB;
                branch      = 1'b1;
                s_done      = 1'b1;
            end
            S_JAL: begin
                s_alu_src_a = SRCA_OLDPC;
                s_alu_src_b = SRCB_FOUR;
                pc_update   = 1'b1;
                state_next  = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // While reset is held, strobes are suppressed and selects show FETCH values.
    always_comb begin
        if (!reset_n) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = RES_ALURESULT;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end else begin
            pc_write   = pc_update | (branch & zero);
            adr_src    = s_adr_src;
            mem_write  = s_mem_write;
            ir_write   = s_ir_write;
            reg_write  = s_reg_write;
            result_src = s_result_src;
            alu_src_a  = s_alu_src_a;
            alu_src_b  = s_alu_src_b;
            alu_op     = s_alu_op;
            instr_done = s_done;
            illegal_op = s_illegal;
        end
    end

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed scenarios plus randomized
// instruction streams checked against a route-based reference model.
module tb_main_fsm;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       instr_done, illegal_op;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       instr_done;
        logic       illegal_op;
    } vec_t;

    vec_t obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal_op};

    int n_cmp  = 0;
    int n_fail = 0;

    // Results of the most recent run_instr call.
    int r_cycles, r_reg_write, r_mem_write, r_ir, r_pc_write, r_done, r_illegal;

    main_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] imm_model(input logic [6:0] o);
        if (o == 7'b0100011)      return 2'b01;
        else if (o == 7'b1100011) return 2'b10;
        else if (o == 7'b1101111) return 2'b11;
        else                      return 2'b00;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Output table by step name; strobes that depend on the handshake use mr / z.
    function automatic vec_t exp_of(input string s, input logic mr, input logic z,
                                    input logic [6:0] o);
        vec_t e;
        e = '0;
        e.imm_src = imm_model(o);
        case (s)
            "FETCH":    begin e.ir_write = mr; e.pc_write = mr;
                              e.alu_src_b = 2'b10; e.result_src = 2'b10; end
            "DECODE":   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            "MEMADR":   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            "MEMREAD":  begin e.adr_src = 1'b1; end
            "MEMWB":    begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            "MEMWRITE": begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            "EXECR":    begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
            "EXECI":    begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
            "ALUWB":    begin e.reg_write = 1'b1; end
            "BEQ":      begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
            "JAL":      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            default:    e = 'x;
        endcase
        return e;
    endfunction

    // Runs one instruction from FETCH back to FETCH, comparing every cycle.
    // fw / mw: number of mem_ready-low cycles in FETCH / in the data access.
    task automatic run_instr(input logic [6:0] opc, input logic zv, input int fw,
                             input int mw, input string tag);
        string route[$];
        bit    bad;
        vec_t  e;
        bad = !is_legal(opc);
        case (opc)
            7'b0000011: route = '{"FETCH", "DECODE", "MEMADR", "MEMREAD", "MEMWB"};
            7'b0100011: route = '{"FETCH", "DECODE", "MEMADR", "MEMWRITE"};
            7'b0110011: route = '{"FETCH", "DECODE", "EXECR", "ALUWB"};
            7'b0010011: route = '{"FETCH", "DECODE", "EXECI", "ALUWB"};
            7'b1100011: route = '{"FETCH", "DECODE", "BEQ"};
            7'b1101111: route = '{"FETCH", "DECODE", "JAL", "ALUWB"};
            default:    route = '{"FETCH", "DECODE"};
        endcase
        r_cycles = 0; r_reg_write = 0; r_mem_write = 0; r_ir = 0;
        r_pc_write = 0; r_done = 0; r_illegal = 0;
        for (int i = 0; i < route.size(); i++) begin
            bit waits_mem;
            int nw;
            waits_mem = (route[i] == "FETCH" || route[i] == "MEMREAD" || route[i] == "MEMWRITE");
            nw = (route[i] == "FETCH") ? fw : (waits_mem ? mw : 0);
            for (int w = 0; w <= nw; w++) begin
                @(negedge clk);
                mem_ready = waits_mem ? (w == nw) : 1'($urandom_range(1, 0));
                op        = (route[i] == "FETCH") ? 7'($urandom_range(127, 0)) : opc;
                zero      = zv;
                #1;
                e = exp_of(route[i], mem_ready, zero, op);
                e.instr_done = (i == route.size() - 1) && !bad && (!waits_mem || mem_ready);
                e.illegal_op = bad && (route[i] == "DECODE");
                n_cmp++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL %s op=%b step=%s wait=%0d: got %b want %b",
                             tag, opc, route[i], w, obs, e);
                end
                r_cycles++;
                r_reg_write += int'(reg_write);
                r_mem_write += int'(mem_write);
                r_ir        += int'(ir_write);
                r_pc_write  += int'(pc_write);
                r_done      += int'(instr_done);
                r_illegal   += int'(illegal_op);
            end
        end
    endtask

    task automatic test_reset();
        vec_t e;
        // Power-up reset: strobes off, FETCH selects.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            op        = 7'b0100011;
            #1;
            e = '0; e.result_src = 2'b10; e.alu_src_b = 2'b10; e.imm_src = 2'b01;
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d: got %b want %b", k, obs, e);
            end
        end
        @(negedge clk); reset_n = 1'b1; mem_ready = 1'b1; op = 7'h00;
        @(negedge clk); op = 7'b0100011;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reach_memwrite: mem_write got %b want 1", mem_write);
        end
        // Reset while storing with memory ready: nothing may be written.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset_n   = 1'b0;
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if ({mem_write, pc_write, ir_write, reg_write, instr_done, illegal_op} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_in_memwrite cyc=%0d: strobes got %b want 000000", k,
                         {mem_write, pc_write, ir_write, reg_write, instr_done, illegal_op});
            end
        end
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        #1;
        e = '0; e.result_src = 2'b10; e.alu_src_b = 2'b10; e.imm_src = imm_model(op);
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_release_fetch: got %b want %b", obs, e);
        end
    endtask

    task automatic test_lw();
        run_instr(7'b0000011, 1'b0, 0, 0, "lw");
        n_cmp++;
        if (r_cycles !== 5 || r_reg_write !== 1 || r_done !== 1 || r_ir !== 1) begin
            n_fail++;
            $display("FAIL lw_summary: cyc/rw/done/ir got %0d/%0d/%0d/%0d want 5/1/1/1",
                     r_cycles, r_reg_write, r_done, r_ir);
        end
    endtask

    task automatic test_beq();
        run_instr(7'b1100011, 1'b1, 0, 0, "beq_taken");
        n_cmp++;
        if (r_cycles !== 3 || r_pc_write !== 2) begin
            n_fail++;
            $display("FAIL beq_taken: cyc/pcw got %0d/%0d want 3/2", r_cycles, r_pc_write);
        end
        run_instr(7'b1100011, 1'b0, 0, 0, "beq_not_taken");
        n_cmp++;
        if (r_cycles !== 3 || r_pc_write !== 1) begin
            n_fail++;
            $display("FAIL beq_not_taken: cyc/pcw got %0d/%0d want 3/1", r_cycles, r_pc_write);
        end
    endtask

    task automatic test_rtype_jal();
        run_instr(7'b0110011, 1'b0, 0, 0, "rtype");
        n_cmp++;
        if (r_cycles !== 4 || r_reg_write !== 1) begin
            n_fail++;
            $display("FAIL rtype: cyc/rw got %0d/%0d want 4/1", r_cycles, r_reg_write);
        end
        run_instr(7'b1101111, 1'b0, 0, 0, "jal");
        n_cmp++;
        if (r_cycles !== 4 || r_pc_write !== 2 || r_reg_write !== 1) begin
            n_fail++;
            $display("FAIL jal: cyc/pcw/rw got %0d/%0d/%0d want 4/2/1",
                     r_cycles, r_pc_write, r_reg_write);
        end
    endtask

    task automatic test_mem_wait();
        run_instr(7'b0100011, 1'b0, 0, 3, "sw_wait");
        n_cmp++;
        if (r_cycles !== 7 || r_mem_write !== 4 || r_done !== 1) begin
            n_fail++;
            $display("FAIL sw_wait: cyc/mw/done got %0d/%0d/%0d want 7/4/1",
                     r_cycles, r_mem_write, r_done);
        end
        run_instr(7'b0010011, 1'b0, 2, 0, "fetch_wait");
        n_cmp++;
        if (r_cycles !== 6 || r_ir !== 1 || r_pc_write !== 1) begin
            n_fail++;
            $display("FAIL fetch_wait: cyc/ir/pcw got %0d/%0d/%0d want 6/1/1",
                     r_cycles, r_ir, r_pc_write);
        end
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 1'b0, 0, 0, "illegal");
        n_cmp++;
        if (r_cycles !== 2 || r_illegal !== 1 || r_reg_write !== 0 ||
            r_mem_write !== 0 || r_done !== 0) begin
            n_fail++;
            $display("FAIL illegal: cyc/ill/rw/mw/done got %0d/%0d/%0d/%0d/%0d want 2/1/0/0/0",
                     r_cycles, r_illegal, r_reg_write, r_mem_write, r_done);
        end
        run_instr(7'b0000011, 1'b0, 1, 1, "after_illegal");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [10];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1111111, 7'b0110111, 7'b0010111, 7'b1100111};
        for (int n = 0; n < 80; n++) begin
            run_instr(ops[$urandom_range(9, 0)], 1'($urandom_range(1, 0)),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), "random");
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = 7'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_beq();
        test_rtype_jal();
        test_mem_wait();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Moore control FSM for the multicycle RISC-V datapath; sits directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath enables and mux selects, and produces the 2-bit ALUOp that the ALU decoder turns into ALUControl.
- Supports lw, sw, R-type, I-type ALU, beq and jal. Waits on a memory-ready handshake.

Parameters:
- none (opcodes and state codes are fixed constants in the shared package)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset; synchronous, active-low (one clock, sampled on rising clk edge)
- op  in  7  instruction opcode, instr[6:0], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  PC load enable = pc_update | (branch & zero)
- adr_src  out  1  0: address is PC, 1: address is ALU result register
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register load enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- alu_op  out  2  00 add, 01 subtract (beq), 10 decode by funct
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- instr_done  out  1  one-cycle pulse on the cycle the FSM returns to FETCH
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- Reset:
  - While reset_n = 0 at a clk edge, the state becomes FETCH.
  - While reset_n is low, all write strobes are forced to 0: pc_write, mem_write, ir_write, reg_write, instr_done, illegal_op.
  - Selects take their FETCH values.
  - Reset mid-instruction abandons that instruction with no partial writes.
- Outputs are decoded from the state (Moore). The only exceptions are pc_write, which also uses zero, and the mem_ready gating below.
- Per-state outputs (signals not listed are 0 / 00):
  - FETCH: adr_src 0, ir_write = mem_ready, pc_update = mem_ready, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10.
  - DECODE: alu_src_a 01, alu_src_b 01, alu_op 00.
  - MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00.
  - MEMREAD: adr_src 1, result_src 00.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: adr_src 1, mem_write 1.
  - EXECR: alu_src_a 10, alu_src_b 00, alu_op 10.
  - EXECI: alu_src_a 10, alu_src_b 01, alu_op 10.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1.
  - JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update 1.
- Transitions:
  - FETCH goes to DECODE only when mem_ready = 1; otherwise it holds, with ir_write and pc_write at 0.
  - DECODE, by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH, with illegal_op pulsed for that cycle
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD holds until mem_ready, then goes to MEMWB.
  - MEMWRITE holds until mem_ready. mem_write stays 1 while holding, and it goes to FETCH on the mem_ready cycle.
  - MEMWB, ALUWB and BEQ -> FETCH. EXECR, EXECI and JAL -> ALUWB.
- instr_done is asserted on any state whose next state is FETCH, except the illegal-op path.
- imm_src is combinational from op:
  - lw, I-type: 00; sw: 01; beq: 10; jal: 11.
  - R-type and illegal: 00.
- Latency in cycles, with zero wait states: lw 5, sw 4, R/I 4, beq 3, jal 4. Each wait cycle with mem_ready = 0 adds 1.
- A mem_ready pulse in a state that does not wait on memory is ignored.
- State is held in a 4-bit register. Unused encodings return to FETCH on the next edge with all strobes 0.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum (11 states, 4-bit);
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp codes and ResultSrc / ALUSrc encodings.
- Sub-module instr_dec: the combinational op -> imm_src table. The FSM instantiates it, and the ALU decoder stays separate at the top level.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles in state MEMWRITE with mem_ready = 1 -> mem_write = 0 throughout; state is FETCH after release.
- lw with mem_ready always 1:
  - state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, then FETCH;
  - reg_write = 1 only in MEMWB; result_src = 01 in MEMWB;
  - instr_done pulses once;
  - ir_write = 1 only in the first cycle.
- beq with zero = 1 in BEQ -> pc_write = 1 and alu_op = 01. Repeat with zero = 0 -> pc_write = 0. Both take 3 cycles.
- R-type (op 0110011) -> alu_op = 10 and alu_src_b = 00 in EXECR. jal -> alu_src_a = 01, alu_src_b = 10, pc_write = 1 in JAL, then ALUWB.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write stays 1 for 4 cycles, then FETCH. FETCH with mem_ready low -> ir_write = 0, pc_write = 0 and no advance.
- Illegal op 1111111 in DECODE -> illegal_op pulses 1 cycle, next state FETCH, no reg_write or mem_write.
